project_soc_usb_ctl_pio: RTL and testbench

PROJECT_SOC_USB_CTL_PIO -- requirements
Module: project_soc_usb_ctl_pio

---
 rtl/project_soc_usb_pkg.sv | 22 ++
 rtl/project_soc_usb_pulse_gen.sv | 75 +++++++
 rtl/project_soc_usb_ctl_pio.sv | 95 +++++++++
 tb/tb_project_soc_usb_ctl_pio.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/project_soc_usb_pkg.sv
// Shared constants for the USB control PIO: register map, pulse FSM encoding, widths.
// The readback option is USB_CTL_PIO_READBACK_EN; it is checked in the top-level file.
package project_soc_usb_pkg;

  localparam int unsigned PORT_W = 8;
  localparam int unsigned PW_W   = 16;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_PW    = 3'd1;
  localparam logic [2:0] ADDR_PULSE = 3'd2;
  localparam logic [2:0] ADDR_SET   = 3'd4;
  localparam logic [2:0] ADDR_CLR   = 3'd5;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_PULSE = 1'b1;

  // A zero width still yields a one-cycle pulse.
  function automatic logic [PW_W-1:0] pulse_reload(input logic [PW_W-1:0] width);
    return (width == '0) ? '0 : width - 1'b1;
  endfunction

endpackage

// File: rtl/project_soc_usb_pulse_gen.sv
// Retriggerable pulse generator: holds a latched bit mask active for max(width,1) cycles.
// Exposes the registered mask and its next-state value so the parent can register its output.
module project_soc_usb_pulse_gen
  import project_soc_usb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_trigger,
  input  logic [PORT_W-1:0] i_mask,
  input  logic [PW_W-1:0]   i_width,
  output logic [PORT_W-1:0] o_active_mask,
  output logic [PORT_W-1:0] o_active_next,
  output logic              o_busy
);

  logic [0:0]        r_state;
  logic [PORT_W-1:0] r_mask;
  logic [PW_W-1:0]   r_cnt;

  logic [0:0]        w_state_nxt;
  logic [PORT_W-1:0] w_mask_nxt;
  logic [PW_W-1:0]   w_cnt_nxt;
  logic              w_fire;

  assign w_fire = i_trigger && (i_mask != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          w_state_nxt = ST_PULSE;
          w_mask_nxt  = i_mask;
          w_cnt_nxt   = pulse_reload(i_width);
        end
      end
      ST_PULSE: begin
        // A trigger wins over expiry, so a retrigger on the final cycle extends the pulse.
        if (w_fire) begin
          w_mask_nxt = r_mask | i_mask;
          w_cnt_nxt  = pulse_reload(i_width);
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_mask_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_active_mask = r_mask;
  assign o_active_next = w_mask_nxt;
  assign o_busy        = (r_state == ST_PULSE);

endmodule

// File: rtl/project_soc_usb_ctl_pio.sv
// Avalon-MM PIO driving USB control lines with set/clear and timed pulse registers.
// Define USB_CTL_PIO_READBACK_EN to enable register readback; otherwise readdata is 0.
module project_soc_usb_ctl_pio
  import project_soc_usb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port
);

  logic [PORT_W-1:0] r_data;
  logic [PW_W-1:0]   r_pw;
  logic [PORT_W-1:0] r_out;

  logic              w_wr;
  logic              w_trig;
  logic [PORT_W-1:0] w_data_nxt;
  logic [PORT_W-1:0] w_active_mask;
  logic [PORT_W-1:0] w_active_next;
  logic              w_busy;

  assign w_wr   = chipselect && !write_n;
  assign w_trig = w_wr && (address == ADDR_PULSE);

  always_comb begin
    w_data_nxt = r_data;
    if (w_wr) begin
      case (address)
        ADDR_DATA: w_data_nxt = writedata[PORT_W-1:0];
        ADDR_SET:  w_data_nxt = r_data | writedata[PORT_W-1:0];
        ADDR_CLR:  w_data_nxt = r_data & ~writedata[PORT_W-1:0];
        default:   w_data_nxt = r_data;
      endcase
    end
  end

  project_soc_usb_pulse_gen u_pulse (
    .i_clk         (clk),
    .i_rst         (reset),
    .i_trigger     (w_trig),
    .i_mask        (writedata[PORT_W-1:0]),
    .i_width       (r_pw),
    .o_active_mask (w_active_mask),
    .o_active_next (w_active_next),
    .o_busy        (w_busy)
  );

  // out_port is registered from next-state values so it changes on the same edge as DATA/FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_pw   <= PW_W'(1);
      r_out  <= '0;
    end else begin
      r_data <= w_data_nxt;
      r_out  <= w_data_nxt | w_active_next;
      if (w_wr && (address == ADDR_PW))
        r_pw <= writedata[PW_W-1:0];
    end
  end

  assign out_port = r_out;

`ifdef USB_CTL_PIO_READBACK_EN
  logic [31:0] r_rd;
  logic        w_unused;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd <= '0;
    end else begin
      case (address)
        ADDR_DATA:  r_rd <= {24'd0, r_data};
        ADDR_PW:    r_rd <= {16'd0, r_pw};
        ADDR_PULSE: r_rd <= {16'd0, w_active_mask, 7'd0, w_busy};
        default:    r_rd <= '0;
      endcase
    end
  end

  assign readdata = r_rd;
  assign w_unused = ^writedata[31:PW_W];
`else
  logic w_unused;

  assign readdata = '0;
  assign w_unused = ^{writedata[31:PW_W], w_active_mask, w_busy};
`endif

endmodule

// File: tb/tb_project_soc_usb_ctl_pio.sv
// Directed self-checking bench for the USB control PIO; readback expectations follow
// USB_CTL_PIO_READBACK_EN (expected 0 when the macro is undefined).
module tb_project_soc_usb_ctl_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write_n;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  project_soc_usb_ctl_pio dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  function automatic logic [31:0] rbx(input logic [31:0] v);
`ifdef USB_CTL_PIO_READBACK_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  // Called at a negedge; returns at the next negedge, after the write edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_port !== 8'h00) begin errors++; $display("FAIL reset_out got %h want %h", out_port, 8'h00); end
    checks++;
    if (readdata !== 32'd0) begin errors++; $display("FAIL reset_rd got %h want %h", readdata, 32'd0); end
    reset = 1'b0;
    rd(3'd1, d);
    checks++;
    if (d !== rbx(32'd1)) begin errors++; $display("FAIL reset_pw got %h want %h", d, rbx(32'd1)); end
  endtask

  task automatic test_data;
    logic [31:0] d;
    wr(3'd0, 32'hFFFF_FFA5);
    checks++;
    if (out_port !== 8'hA5) begin errors++; $display("FAIL data_out got %h want %h", out_port, 8'hA5); end
    rd(3'd0, d);
    checks++;
    if (d !== rbx(32'h0000_00A5)) begin errors++; $display("FAIL data_rd got %h want %h", d, rbx(32'h0000_00A5)); end
  endtask

  task automatic test_set_clear;
    wr(3'd0, 32'h0F);
    wr(3'd4, 32'h30);
    checks++;
    if (out_port !== 8'h3F) begin errors++; $display("FAIL outset got %h want %h", out_port, 8'h3F); end
    wr(3'd5, 32'h03);
    checks++;
    if (out_port !== 8'h3C) begin errors++; $display("FAIL outclear got %h want %h", out_port, 8'h3C); end
  endtask

  task automatic test_noop;
    logic [31:0] d;
    wr(3'd3, 32'hFF);
    wr(3'd6, 32'hFF);
    wr(3'd7, 32'hFF);
    checks++;
    if (out_port !== 8'h3C) begin errors++; $display("FAIL noop_out got %h want %h", out_port, 8'h3C); end
    rd(3'd3, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL noop_rd got %h want %h", d, 32'd0); end
    // Zero-mask trigger must not start a pulse.
    wr(3'd2, 32'h00);
    rd(3'd2, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL zero_mask_busy got %h want %h", d, 32'd0); end
    checks++;
    if (out_port !== 8'h3C) begin errors++; $display("FAIL zero_mask_out got %h want %h", out_port, 8'h3C); end
  endtask

  task automatic test_pulse;
    logic [7:0]  eo;
    logic [31:0] er;
    wr(3'd0, 32'h00);
    wr(3'd1, 32'd5);
    wr(3'd2, 32'h01);
    for (int k = 0; k < 8; k++) begin
      eo = (k < 5) ? 8'h01 : 8'h00;
      er = (k >= 1 && k <= 5) ? rbx(32'h0000_0101) : 32'd0;
      checks++;
      if (out_port !== eo) begin errors++; $display("FAIL pulse5_out k=%0d got %h want %h", k, out_port, eo); end
      checks++;
      if (readdata !== er) begin errors++; $display("FAIL pulse5_busy k=%0d got %h want %h", k, readdata, er); end
      @(negedge clk);
    end
  endtask

  task automatic test_pulse_zero_width;
    logic [7:0] eo;
    wr(3'd1, 32'd0);
    wr(3'd2, 32'h80);
    for (int k = 0; k < 3; k++) begin
      eo = (k == 0) ? 8'h80 : 8'h00;
      checks++;
      if (out_port !== eo) begin errors++; $display("FAIL pulse0_out k=%0d got %h want %h", k, out_port, eo); end
      @(negedge clk);
    end
  endtask

  task automatic test_retrigger;
    logic [7:0] eo;
    wr(3'd1, 32'd4);
    wr(3'd2, 32'h01);
    for (int k = 0; k < 9; k++) begin
      eo = {6'd0, (k >= 2 && k <= 5), (k <= 5)};
      checks++;
      if (out_port !== eo) begin errors++; $display("FAIL retrig_out k=%0d got %h want %h", k, out_port, eo); end
      if (k == 1) begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd2; writedata = 32'h02;
      end else begin
        chipselect = 1'b0; write_n = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_width_change_mid_pulse;
    logic [7:0] eo;
    wr(3'd1, 32'd3);
    wr(3'd2, 32'h04);
    wr(3'd1, 32'd1);
    for (int k = 1; k < 5; k++) begin
      eo = (k < 3) ? 8'h04 : 8'h00;
      checks++;
      if (out_port !== eo) begin errors++; $display("FAIL pw_mid_out k=%0d got %h want %h", k, out_port, eo); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_pulse;
    logic [31:0] d;
    wr(3'd1, 32'd10);
    wr(3'd2, 32'h01);
    @(negedge clk);
    reset = 1'b1;
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'hFF;
    @(negedge clk);
    checks++;
    if (out_port !== 8'h00) begin errors++; $display("FAIL rst_mid_out got %h want %h", out_port, 8'h00); end
    reset = 1'b0;
    chipselect = 1'b0; write_n = 1'b1;
    rd(3'd2, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL rst_mid_busy got %h want %h", d, 32'd0); end
    checks++;
    if (out_port !== 8'h00) begin errors++; $display("FAIL rst_mid_out2 got %h want %h", out_port, 8'h00); end
    rd(3'd1, d);
    checks++;
    if (d !== rbx(32'd1)) begin errors++; $display("FAIL rst_mid_pw got %h want %h", d, rbx(32'd1)); end
  endtask

  initial begin
    test_reset;
    test_data;
    test_set_clear;
    test_noop;
    test_pulse;
    test_pulse_zero_width;
    test_retrigger;
    test_width_change_mid_pulse;
    test_reset_mid_pulse;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
